// File: rtl/afpm_pkg.sv
// Shared types and constants for the AFPM byte-serial I/O sequencer.
// Holds the sequencer state encoding, the default operand width and index sizing.
package afpm_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } afpm_state_e;

    localparam int AFPM_WIDTH = 16;

    // Index width for a byte counter; never narrower than one bit.
    function automatic int afpm_idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

    localparam int AFPM_NBYTES = AFPM_WIDTH / 8;
    localparam int AFPM_IDX_W  = afpm_idx_width(AFPM_NBYTES);

endpackage

// File: rtl/afpm_byte_lane.sv
// Byte-addressed word register: indexed byte write, whole-word load and indexed byte read.
// Used for both operand lanes and the result buffer of the sequencer.
module afpm_byte_lane #(
    parameter int NBYTES = 2,
    parameter int IDX_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_byte,
    input  logic                  ld_en,
    input  logic [NBYTES*8-1:0]   ld_word,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [NBYTES*8-1:0]   word_o,
    output logic [7:0]            rd_byte_o
);

    logic [NBYTES*8-1:0] word_r;
    logic [7:0]          rd_byte_s;

    // Storage: a whole-word load takes priority over a single byte write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= {(NBYTES*8){1'b0}};
        end else if (ena && ld_en) begin
            word_r <= ld_word;
        end else if (ena && wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    word_r[8*i +: 8] <= wr_byte;
                end
            end
        end
    end

    // Indexed byte read as an AND-OR mux over the stored bytes.
    always_comb begin
        rd_byte_s = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            rd_byte_s = rd_byte_s | (word_r[8*i +: 8] & {8{rd_idx == IDX_W'(i)}});
        end
    end

    assign word_o    = word_r;
    assign rd_byte_o = rd_byte_s;

endmodule

// File: rtl/afpm_io_sequencer.sv
// Byte-serial I/O sequencer for the AFPM core: assembles two operands low byte first,
// hands them to the core over valid/ready, then streams the result back low byte first.
module afpm_io_sequencer
    import afpm_pkg::*;
#(
    parameter int WIDTH = AFPM_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        byte_a_i,
    input  logic [7:0]        byte_b_i,
    output logic [WIDTH-1:0]  mul_a_o,
    output logic [WIDTH-1:0]  mul_b_o,
    output logic              mul_valid_o,
    input  logic              mul_ready_i,
    input  logic              res_valid_i,
    input  logic [WIDTH-1:0]  res_i,
    output logic [7:0]        out_byte_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = afpm_idx_width(NBYTES);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    afpm_state_e       state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              mul_valid_r, mul_valid_s;
    logic              out_valid_r, out_valid_s;
    logic              busy_r, busy_s;
    logic              err_r, err_s;
    logic [7:0]        out_byte_r, out_byte_s;
    logic              ab_wr_s;
    logic              res_ld_s;
    logic [IDX_W-1:0]  res_rd_idx_s;

    logic [WIDTH-1:0]  a_word_s, b_word_s, res_word_s;
    logic [7:0]        a_rd_s, b_rd_s, res_rd_s;
    logic [WIDTH+15:0] unused_lane_bits_s;

    // The result lane is read one byte ahead so the next output byte is ready to register.
    assign res_rd_idx_s = idx_r + IDX_ONE;

    afpm_byte_lane #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (ab_wr_s),
        .wr_idx    (idx_r),
        .wr_byte   (byte_a_i),
        .ld_en     (1'b0),
        .ld_word   ({WIDTH{1'b0}}),
        .rd_idx    (IDX_ZERO),
        .word_o    (a_word_s),
        .rd_byte_o (a_rd_s)
    );

    afpm_byte_lane #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (ab_wr_s),
        .wr_idx    (idx_r),
        .wr_byte   (byte_b_i),
        .ld_en     (1'b0),
        .ld_word   ({WIDTH{1'b0}}),
        .rd_idx    (IDX_ZERO),
        .word_o    (b_word_s),
        .rd_byte_o (b_rd_s)
    );

    afpm_byte_lane #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_lane_res (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (1'b0),
        .wr_idx    (IDX_ZERO),
        .wr_byte   (8'h00),
        .ld_en     (res_ld_s),
        .ld_word   (res_i),
        .rd_idx    (res_rd_idx_s),
        .word_o    (res_word_s),
        .rd_byte_o (res_rd_s)
    );

    assign unused_lane_bits_s = {a_rd_s, b_rd_s, res_word_s};

    // Next-state, index and registered-output decode; everything holds while ena is low.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        mul_valid_s = mul_valid_r;
        out_valid_s = out_valid_r;
        busy_s      = busy_r;
        err_s       = err_r;
        out_byte_s  = out_byte_r;
        ab_wr_s     = 1'b0;
        res_ld_s    = 1'b0;
        if (ena) begin
            // Any strobe outside WAIT is a protocol error, including one coinciding with the handshake.
            err_s = err_r | (res_valid_i & (state_r != WAIT));
            case (state_r)
                LOAD: begin
                    ab_wr_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        state_s = ISSUE;
                        idx_s   = IDX_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end
                ISSUE: begin
                    if (mul_ready_i) begin
                        state_s = WAIT;
                    end else begin
                        state_s = ISSUE;
                    end
                end
                WAIT: begin
                    if (res_valid_i) begin
                        res_ld_s   = 1'b1;
                        out_byte_s = res_i[7:0];
                        idx_s      = IDX_ZERO;
                        state_s    = OUT;
                    end else begin
                        state_s = WAIT;
                    end
                end
                OUT: begin
                    if (idx_r == IDX_LAST) begin
                        state_s = LOAD;
                        idx_s   = IDX_ZERO;
                    end else begin
                        idx_s      = idx_r + IDX_ONE;
                        out_byte_s = res_rd_s;
                    end
                end
                default: begin
                    state_s = LOAD;
                    idx_s   = IDX_ZERO;
                end
            endcase
            mul_valid_s = (state_s == ISSUE);
            out_valid_s = (state_s == OUT);
            busy_s      = (state_s != LOAD);
        end else begin
            state_s     = state_r;
            idx_s       = idx_r;
            mul_valid_s = mul_valid_r;
            out_valid_s = out_valid_r;
            busy_s      = busy_r;
            err_s       = err_r;
            out_byte_s  = out_byte_r;
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD;
            idx_r       <= IDX_ZERO;
            mul_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            out_byte_r  <= 8'h00;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            mul_valid_r <= mul_valid_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
            out_byte_r  <= out_byte_s;
        end
    end

    assign mul_a_o     = a_word_s;
    assign mul_b_o     = b_word_s;
    assign mul_valid_o = mul_valid_r;
    assign out_byte_o  = out_byte_r;
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

endmodule
